// File: rtl/flag_gen_128bit_if.sv
// flag_gen_128bit_if: ALU result/opcode inputs and registered status flags
interface flag_gen_128bit_if #(parameter int WIDTH = 128);
    logic [2:0]       opsel;
    logic             mode;
    logic             cin;
    logic [WIDTH-1:0] result;
    logic             c_flag;
    logic             z_flag;
    logic             s_flag;
    logic             o_flag;
    modport master (output opsel, mode, cin, result, input c_flag, z_flag, s_flag, o_flag);
    modport slave (input opsel, mode, cin, result, output c_flag, z_flag, s_flag, o_flag);
endinterface

// File: rtl/flag_gen_128bit.sv
// flag_gen_128bit: registered C/Z/S/O status flags derived from the ALU result
module flag_gen_128bit #(
    parameter int WIDTH = 128
) (
    input logic             clk,
    input logic             rst_n,
    flag_gen_128bit_if.slave bus
);
    logic msb, c_next, o_next;
    always_comb begin
        msb = bus.result[WIDTH-1];
        // arithmetic: ADD/ADDC/INC pass carry, SUB/SUBB/DEC invert it as borrow
        c_next = bus.mode ? (bus.opsel[2] & bus.cin)
               : (bus.opsel == 3'd0 || bus.opsel == 3'd1 || bus.opsel == 3'd4) ? bus.cin
               : (bus.opsel == 3'd2 || bus.opsel == 3'd3 || bus.opsel == 3'd5) ? ~bus.cin
               : 1'b0;
        o_next = bus.mode ? (bus.opsel == 3'd4 && (bus.cin ^ msb))
               : (bus.opsel <= 3'd5 && (bus.cin ^ msb));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.c_flag <= 1'b0;
            bus.z_flag <= 1'b0;
            bus.s_flag <= 1'b0;
            bus.o_flag <= 1'b0;
        end else begin
            bus.c_flag <= c_next;
            bus.z_flag <= ~|bus.result;
            bus.s_flag <= msb;
            bus.o_flag <= o_next;
        end
    end
endmodule

// File: tb/tb_flag_gen_128bit.sv
// tb_flag_gen_128bit: directed vectors for flag_gen_128bit, flags checked as {c,z,s,o}
module tb_flag_gen_128bit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    localparam logic [127:0] ZERO = '0;
    localparam logic [127:0] ONES = '1;
    localparam logic [127:0] TOP  = {1'b1, 127'b0};
    flag_gen_128bit_if #(.WIDTH(128)) bus ();
    flag_gen_128bit #(.WIDTH(128)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {bus.c_flag, bus.z_flag, bus.s_flag, bus.o_flag};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed czso=%b expected czso=%b", tag, obs, exp);
        end
    endtask
    task automatic step(input string tag, input logic m, input logic [2:0] op, input logic ci,
                        input logic [127:0] res, input logic [3:0] exp);
        bus.mode = m;
        bus.opsel = op;
        bus.cin = ci;
        bus.result = res;
        @(posedge clk);
        @(negedge clk);
        check(tag, exp);
    endtask
    initial begin
        bus.mode = 1'b0;
        bus.opsel = 3'd0;
        bus.cin = 1'b1;
        bus.result = ZERO;
        repeat (3) @(negedge clk);
        check("reset_hold", 4'b0000);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_release", 4'b1101);
        step("add_wrap",     1'b0, 3'd0, 1'b1, ZERO, 4'b1101);
        step("add_plain",    1'b0, 3'd0, 1'b0, 128'd1, 4'b0000);
        step("sub_borrow",   1'b0, 3'd2, 1'b0, ONES, 4'b1011);
        step("sub_noborrow", 1'b0, 3'd2, 1'b1, ONES, 4'b0010);
        step("xor_clear",    1'b1, 3'd2, 1'b1, TOP,  4'b0010);
        step("shl_ovf",      1'b1, 3'd4, 1'b0, TOP,  4'b0011);
        step("asr_no_ovf",   1'b1, 3'd6, 1'b0, TOP,  4'b0010);
        step("shl_carry",    1'b1, 3'd4, 1'b1, TOP,  4'b1010);
        step("dec_borrow",   1'b0, 3'd5, 1'b0, ZERO, 4'b1100);
        step("inc_wrap",     1'b0, 3'd4, 1'b1, ZERO, 4'b1101);
        step("pass_ones",    1'b0, 3'd6, 1'b1, ONES, 4'b0010);
        step("reserved",     1'b0, 3'd7, 1'b1, ZERO, 4'b0100);
        step("rol_carry",    1'b1, 3'd7, 1'b1, 128'd1, 4'b1000);
        step("addc_top",     1'b0, 3'd1, 1'b1, TOP,  4'b1010);
        step("subb_borrow",  1'b0, 3'd3, 1'b0, 128'd5, 4'b1000);
        step("not_zero",     1'b1, 3'd3, 1'b1, ZERO, 4'b0100);
        step("shr_carry",    1'b1, 3'd5, 1'b1, TOP,  4'b1010);
        step("and_ones",     1'b1, 3'd0, 1'b1, ONES, 4'b0010);
        step("or_mid",       1'b1, 3'd1, 1'b0, 128'h1_0000_0000_0000_0000, 4'b0000);
        step("pre_async",    1'b0, 3'd2, 1'b0, ONES, 4'b1011);
        #1 rst_n = 1'b0;
        #1 check("async_clear", 4'b0000);
        #1 rst_n = 1'b1;
        bus.mode = 1'b1;
        bus.opsel = 3'd4;
        bus.cin = 1'b1;
        bus.result = 128'd2;
        #1 check("async_hold", 4'b0000);
        @(posedge clk);
        @(negedge clk);
        check("post_async", 4'b1001);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/flag_gen_128bit.md
Name:
flag_gen_128bit

Overview:
- Status-flag generator for the 128-bit ALU; sits directly after the ALU datapath.
- Takes the 128-bit ALU result, the datapath carry/shift-out bit and the operation code.
- Produces registered carry (C), zero (Z), sign (S) and overflow (O) flags for the status register and branch logic.

Parameters:
- WIDTH, 128, result width in bits; MSB index is WIDTH-1.

Ports:
- clk  input  1  system clock; all flag registers update on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- opsel  input  3  operation select (encoding below).
- mode  input  1  0 = arithmetic group, 1 = logic/shift group.
- cin  input  1  carry/shift-out bit from the datapath: adder carry-out of bit WIDTH-1 for arithmetic ops; bit shifted or rotated out for shift/rotate ops.
- result  input  WIDTH  ALU result for the current operation.
- c_flag  output  1  carry/borrow flag, registered.
- z_flag  output  1  zero flag, registered.
- s_flag  output  1  sign flag, registered.
- o_flag  output  1  overflow flag, registered.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n = 0, all four flags are forced to 0 immediately, independent of clk.
  - On reset release, flags stay 0 until the first rising clk edge.
- Latency:
  - Inputs are sampled on each rising clk edge; flags reflect them one cycle later.
  - Flags update every cycle; there is no enable and no handshake.
  - Each update depends only on the inputs sampled at that edge, with no memory of earlier cycles.
- Opcode encoding, mode = 0 (arithmetic):
  - 000 ADD, 001 ADDC, 010 SUB, 011 SUBB, 100 INC, 101 DEC, 110 PASS, 111 reserved.
- Opcode encoding, mode = 1 (logic/shift):
  - 000 AND, 001 OR, 010 XOR, 011 NOT, 100 SHL, 101 SHR, 110 ASR, 111 ROL.
- z_flag = 1 iff result == 0, for every opcode including reserved.
- s_flag = result[WIDTH-1] for every opcode.
- c_flag:
  - ADD, ADDC, INC: c_flag = cin.
  - SUB, SUBB, DEC: c_flag = ~cin (borrow convention).
  - SHL, SHR, ASR, ROL: c_flag = cin.
  - PASS, reserved, AND, OR, XOR, NOT: c_flag = 0.
- o_flag:
  - ADD, ADDC, SUB, SUBB, INC, DEC: o_flag = cin XOR result[WIDTH-1].
  - ASR: o_flag = 0.
  - SHL: o_flag = cin XOR result[WIDTH-1] (sign changed by the shift).
  - All other opcodes: o_flag = 0.
- Inputs containing X/Z are not handled specially.
- Boundary values:
  - result all-zero gives Z = 1 and S = 0.
  - result all-ones gives Z = 0 and S = 1.
  - A change of mode or opsel between cycles takes effect on the next edge with no residual state.
  - A reset asserted mid-stream clears the flags in the same cycle; the first post-reset edge loads fresh flags.

Test Plan:
- Reset: hold rst_n = 0 with result = 0, mode = 0, opsel = 000, cin = 1 -> all flags 0. Release and clock once -> z = 1, c = 1, s = 0, o = 1.
- ADD wrap: mode = 0, opsel = 000, result = 0, cin = 1 -> one cycle later c = 1, z = 1, s = 0, o = 1.
- SUB borrow: mode = 0, opsel = 010, result = all-ones, cin = 0 -> c = 1, z = 0, s = 1, o = 1. Same with cin = 1 -> c = 0, o = 0.
- Logic clears C/O: mode = 1, opsel = 010, result = 128'h8000…0, cin = 1 -> c = 0, o = 0, s = 1, z = 0.
- Shift: mode = 1, opsel = 100, result = 128'h8000…0, cin = 0 -> c = 0, o = 1, s = 1. Same inputs with opsel = 110 (ASR) -> o = 0.
- Async reset mid-run: flags nonzero, pulse rst_n low between clock edges -> flags go 0 immediately, before the next edge.
